regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port (RegWrite/RD/WriteData) between two requesters:
//  the pipeline writeback stage (WB) and a multi-cycle unit (MC, e.g. divider or load-miss return).

---
 rtl/regfile_write_arbiter_if.sv | 27 ++
 rtl/regfile_write_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Request bundle for the register-file write arbiter.
// Carries the WB and MC valid/ready write requests.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              mc_valid;
    logic              mc_ready;
    logic [ADDR_W-1:0] mc_rd;
    logic [DATA_W-1:0] mc_data;

    modport master (
        output wb_valid, wb_rd, wb_data,
        output mc_valid, mc_rd, mc_data,
        input  wb_ready, mc_ready
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  mc_valid, mc_rd, mc_data,
        output wb_ready, mc_ready
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between WB and MC.
// Optional same-cycle bypass ports: define REGFILE_ARB_BYPASS_EN.
module regfile_write_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_write_arbiter_if.slave req,
    output logic                  RegWrite,
    output logic [ADDR_W-1:0]     RD,
    output logic [DATA_W-1:0]     WriteData,
`ifdef REGFILE_ARB_BYPASS_EN
    input  logic [ADDR_W-1:0]     byp_rs1,
    input  logic [ADDR_W-1:0]     byp_rs2,
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [DATA_W-1:0]     byp_data1,
    output logic [DATA_W-1:0]     byp_data2,
`endif
    output logic [3:0]            starve_cnt
);
    localparam logic [3:0] LP_SMAX = 4'(STARVE_MAX);

    logic              r_we;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_data;
    logic [3:0]        r_starve;

    logic              w_gnt;
    logic              w_mc_win;
    logic              w_mc_ack;
    logic [ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0] w_data;
    logic [3:0]        w_starve_nxt;

    // Grant selection, ready generation and starvation counter update.
    always_comb begin
        w_mc_win     = 1'b0;
        w_mc_ack     = 1'b0;
        w_gnt        = 1'b0;
        w_rd         = req.wb_rd;
        w_data       = req.wb_data;
        req.wb_ready = 1'b0;
        req.mc_ready = 1'b0;
        w_starve_nxt = r_starve;
        if (reset) begin
            if (req.wb_valid && req.mc_valid) begin
                if (req.wb_rd == req.mc_rd) begin
                    w_mc_ack = 1'b1;
                end else if (r_starve == LP_SMAX) begin
                    w_mc_win = 1'b1;
                    w_mc_ack = 1'b1;
                end
            end else if (req.mc_valid) begin
                w_mc_win = 1'b1;
                w_mc_ack = 1'b1;
            end
            w_gnt        = req.wb_valid || req.mc_valid;
            req.wb_ready = req.wb_valid && !w_mc_win;
            req.mc_ready = w_mc_ack;
            if (w_mc_win) begin
                w_rd   = req.mc_rd;
                w_data = req.mc_data;
            end
            if (!req.mc_valid || w_mc_ack) begin
                w_starve_nxt = 4'd0;
            end else if (r_starve < LP_SMAX) begin
                w_starve_nxt = r_starve + 4'd1;
            end
        end
    end

    // Output register; x0 and idle cycles leave RD/WriteData unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we     <= 1'b0;
            r_rd     <= '0;
            r_data   <= '0;
            r_starve <= 4'd0;
        end else begin
            r_we     <= w_gnt && (w_rd != '0);
            r_starve <= w_starve_nxt;
            if (w_gnt && (w_rd != '0)) begin
                r_rd   <= w_rd;
                r_data <= w_data;
            end
        end
    end

    assign RegWrite   = r_we;
    assign RD         = r_rd;
    assign WriteData  = r_data;
    assign starve_cnt = r_starve;

`ifdef REGFILE_ARB_BYPASS_EN
    assign byp_hit1  = r_we && (r_rd == byp_rs1) && (r_rd != '0);
    assign byp_hit2  = r_we && (r_rd == byp_rs2) && (r_rd != '0);
    assign byp_data1 = byp_hit1 ? r_data : '0;
    assign byp_data2 = byp_hit2 ? r_data : '0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter.
// Expected commits are queued with their cycle; a monitor checks them.
module tb_regfile_write_arbiter;
    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  RD;
    logic [63:0] WriteData;
    logic [3:0]  starve_cnt;
`ifdef REGFILE_ARB_BYPASS_EN
    logic [4:0]  byp_rs1;
    logic [4:0]  byp_rs2;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [63:0] byp_data1;
    logic [63:0] byp_data2;
`endif

    int   n_tests;
    int   n_fail;
    int   cyc;
    exp_t sb[$];

    regfile_write_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();

    regfile_write_arbiter #(
        .DATA_W(64), .ADDR_W(5), .STARVE_MAX(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (bus.slave),
        .RegWrite   (RegWrite),
        .RD         (RD),
        .WriteData  (WriteData),
`ifdef REGFILE_ARB_BYPASS_EN
        .byp_rs1    (byp_rs1),
        .byp_rs2    (byp_rs2),
        .byp_hit1   (byp_hit1),
        .byp_hit2   (byp_hit2),
        .byp_data1  (byp_data1),
        .byp_data2  (byp_data2),
`endif
        .starve_cnt (starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [63:0] d);
        exp_t e;
        e.cyc  = cyc + 1;
        e.rd   = rd;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd,
                      input logic [63:0] d);
        bus.wb_valid = v;
        bus.wb_rd    = rd;
        bus.wb_data  = d;
    endtask

    task automatic mc(input logic v, input logic [4:0] rd,
                      input logic [63:0] d);
        bus.mc_valid = v;
        bus.mc_rd    = rd;
        bus.mc_data  = d;
    endtask

    // Monitor: every committed write must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset && RegWrite) begin
            n_tests = n_tests + 1;
            if (sb.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL commit: unexpected write rd=%0d data=0x%0h cyc=%0d",
                         RD, WriteData, cyc);
            end else begin
                e = sb.pop_front();
                if (RD !== e.rd || WriteData !== e.data || cyc != e.cyc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL commit: got rd=%0d data=0x%0h cyc=%0d expected rd=%0d data=0x%0h cyc=%0d",
                             RD, WriteData, cyc, e.rd, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        reset   = 1'b0;
        wb(1'b0, 5'd0, 64'd0);
        mc(1'b0, 5'd0, 64'd0);
`ifdef REGFILE_ARB_BYPASS_EN
        byp_rs1 = 5'd0;
        byp_rs2 = 5'd0;
`endif
        #1;
        chk("rst_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("rst_rd", {59'd0, RD}, 64'd0);
        chk("rst_wdata", WriteData, 64'd0);
        chk("rst_starve", {60'd0, starve_cnt}, 64'd0);
        step();
        step();
        reset = 1'b1;

        // Write in flight is discarded by a mid-stream reset.
        wb(1'b1, 5'd2, 64'h77);
        #1;
        chk("pre_rst_wb_ready", {63'd0, bus.wb_ready}, 64'd1);
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("mid_rst_rd", {59'd0, RD}, 64'd0);
        chk("mid_rst_wb_ready", {63'd0, bus.wb_ready}, 64'd0);
        chk("mid_rst_mc_ready", {63'd0, bus.mc_ready}, 64'd0);
        step();
        step();
        reset = 1'b1;

        // Plain WB write.
        wb(1'b1, 5'd5, 64'hAA);
        #1;
        chk("t1_wb_ready", {63'd0, bus.wb_ready}, 64'd1);
        push(5'd5, 64'hAA);
        step();

        // x0 write is acked but never committed.
        wb(1'b1, 5'd0, 64'h55);
        #1;
        chk("t2_wb_ready", {63'd0, bus.wb_ready}, 64'd1);
        step();
        wb(1'b0, 5'd0, 64'd0);
        #1;
        chk("t2_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("t2_rd_hold", {59'd0, RD}, 64'd5);
        chk("t2_wdata_hold", WriteData, 64'hAA);

        // Same destination: WB wins, MC acked and dropped.
        wb(1'b1, 5'd7, 64'h11);
        mc(1'b1, 5'd7, 64'h22);
        #1;
        chk("t3_wb_ready", {63'd0, bus.wb_ready}, 64'd1);
        chk("t3_mc_ready", {63'd0, bus.mc_ready}, 64'd1);
        push(5'd7, 64'h11);
        step();
        wb(1'b0, 5'd0, 64'd0);
        mc(1'b0, 5'd0, 64'd0);
        step();
        chk("idle_regwrite", {63'd0, RegWrite}, 64'd0);

        // Starvation: MC loses four times then is forced through.
        mc(1'b1, 5'd9, 64'h99);
        for (int k = 0; k < 4; k++) begin
            wb(1'b1, 5'(k + 1), 64'(256 + k));
            #1;
            chk("t4_starve", {60'd0, starve_cnt}, 64'(k));
            chk("t4_mc_lose", {63'd0, bus.mc_ready}, 64'd0);
            push(5'(k + 1), 64'(256 + k));
            step();
        end
        wb(1'b1, 5'd5, 64'h155);
        #1;
        chk("t4_starve_max", {60'd0, starve_cnt}, 64'd4);
        chk("t4_mc_win", {63'd0, bus.mc_ready}, 64'd1);
        chk("t4_wb_wait", {63'd0, bus.wb_ready}, 64'd0);
        push(5'd9, 64'h99);
        step();
        mc(1'b0, 5'd0, 64'd0);
        #1;
        chk("t4_starve_clr", {60'd0, starve_cnt}, 64'd0);
        chk("t4_wb_resume", {63'd0, bus.wb_ready}, 64'd1);
        push(5'd5, 64'h155);
        step();

        // Back-to-back alternating single requests.
        wb(1'b1, 5'd3, 64'h33);
        push(5'd3, 64'h33);
        step();
        wb(1'b0, 5'd0, 64'd0);
        mc(1'b1, 5'd4, 64'h44);
        #1;
        chk("t5_mc_ready", {63'd0, bus.mc_ready}, 64'd1);
        push(5'd4, 64'h44);
        step();
        mc(1'b0, 5'd0, 64'd0);
        wb(1'b1, 5'd6, 64'h66);
        push(5'd6, 64'h66);
        step();
        wb(1'b0, 5'd0, 64'd0);

`ifdef REGFILE_ARB_BYPASS_EN
        wb(1'b1, 5'd12, 64'h3C);
        push(5'd12, 64'h3C);
        step();
        wb(1'b0, 5'd0, 64'd0);
        byp_rs1 = 5'd12;
        byp_rs2 = 5'd13;
        #1;
        chk("t6_hit1", {63'd0, byp_hit1}, 64'd1);
        chk("t6_data1", byp_data1, 64'h3C);
        chk("t6_hit2", {63'd0, byp_hit2}, 64'd0);
        chk("t6_data2", byp_data2, 64'd0);
`endif

        step();
        step();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
